// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared definitions for the Game of Life map controller:
//   - sequencer state enum
//   - preset pattern identifiers
//   - cell-address tables of the preset patterns (address = y*16 + x)
//   - pulsar address generator (the 48-cell pulsar is built from two small
//     coordinate lists instead of a 48-entry table)
// ---------------------------------------------------------------------------
package life_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_EDIT,
        ST_CLR,
        ST_LOAD,
        ST_FILL
    } state_e;

    typedef enum logic [1:0] {
        PAT_CLEAR  = 2'd0,
        PAT_GLIDER = 2'd1,
        PAT_LWSS   = 2'd2,
        PAT_PULSAR = 2'd3
    } pat_e;

    localparam int GLIDER_LEN = 5;
    localparam int LWSS_LEN   = 9;
    localparam int PULSAR_LEN = 48;

    // Entry 0 sits in the least significant byte.
    localparam logic [GLIDER_LEN*8-1:0] GLIDER_CELLS =
        {8'd33, 8'd32, 8'd18, 8'd17, 8'd0};
    localparam logic [LWSS_LEN*8-1:0] LWSS_CELLS =
        {8'd153, 8'd152, 8'd151, 8'd150, 8'd137, 8'd133, 8'd121, 8'd104, 8'd101};

    // Pulsar in its 13x13 bounding box: live cells lie on rows {0,5,7,12}
    // across columns {2,3,4,8,9,10}, plus the transpose of that set.
    localparam logic [15:0] PULSAR_EDGE = {4'd12, 4'd7, 4'd5, 4'd0};
    localparam logic [23:0] PULSAR_SPAN = {4'd10, 4'd9, 4'd8, 4'd4, 4'd3, 4'd2};
    // Offset of the bounding box so the pulsar sits in the middle of 16x16.
    localparam logic [3:0]  PULSAR_ORG  = 4'd1;

    // Indices 0..23 walk the horizontal bars, 24..47 the vertical bars.
    function automatic logic [7:0] pulsar_addr(input logic [5:0] idx);
        logic [5:0] j;
        logic [5:0] q;
        logic [5:0] m;
        logic [3:0] e;
        logic [3:0] s;
        logic [3:0] row;
        logic [3:0] col;
        j = (idx >= 6'd24) ? (idx - 6'd24) : idx;
        q = j / 6'd6;
        m = j % 6'd6;
        e = PULSAR_EDGE[{q[1:0], 2'b00} +: 4];
        s = PULSAR_SPAN[{m[2:0], 2'b00} +: 4];
        if (idx < 6'd24) begin
            row = e;
            col = s;
        end else begin
            row = s;
            col = e;
        end
        return {row + PULSAR_ORG, col + PULSAR_ORG};
    endfunction

endpackage

// File: rtl/life_ctrl_if.sv
// ---------------------------------------------------------------------------
// life_ctrl_if
// Bundle between user controls / rate counter (master side) and the
// life_ctrl sequencer (slave side).
//   requests : run, tick, step_req, edit_req, edit_x, edit_y, pat_req,
//              pat_sel, rand_req
//   commands : gen_en, map_clr, wr_en, wr_op, wr_addr, wr_data
//   status   : busy, gen_count, overrun
// ---------------------------------------------------------------------------
interface life_ctrl_if;
    logic        run;
    logic        tick;
    logic        step_req;
    logic        edit_req;
    logic [3:0]  edit_x;
    logic [3:0]  edit_y;
    logic        pat_req;
    logic [1:0]  pat_sel;
    logic        rand_req;

    logic        gen_en;
    logic        map_clr;
    logic        wr_en;
    logic        wr_op;
    logic [7:0]  wr_addr;
    logic        wr_data;
    logic        busy;
    logic [15:0] gen_count;
    logic        overrun;

    modport master (
        output run, tick, step_req, edit_req, edit_x, edit_y,
               pat_req, pat_sel, rand_req,
        input  gen_en, map_clr, wr_en, wr_op, wr_addr, wr_data,
               busy, gen_count, overrun
    );

    modport slave (
        input  run, tick, step_req, edit_req, edit_x, edit_y,
               pat_req, pat_sel, rand_req,
        output gen_en, map_clr, wr_en, wr_op, wr_addr, wr_data,
               busy, gen_count, overrun
    );
endinterface

// File: rtl/life_pattern_rom.sv
// ---------------------------------------------------------------------------
// life_pattern_rom
// Combinational lookup of preset pattern cells.
//   pat_sel : pattern to read
//   index   : cell number within the pattern
//   addr    : cell address (y*16 + x)
//   last    : index is the final cell of the pattern (also 1 for the empty
//             pattern and for out-of-range indices, so a walk always ends)
// ---------------------------------------------------------------------------
module life_pattern_rom
    import life_pkg::*;
(
    input  pat_e       pat_sel,
    input  logic [5:0] index,
    output logic [7:0] addr,
    output logic       last
);

    always_comb begin
        addr = '0;
        last = 1'b1;
        case (pat_sel)
            PAT_GLIDER: begin
                if (index < 6'(GLIDER_LEN)) begin
                    addr = GLIDER_CELLS[{index[2:0], 3'b000} +: 8];
                    last = (index == 6'(GLIDER_LEN - 1));
                end
            end
            PAT_LWSS: begin
                if (index < 6'(LWSS_LEN)) begin
                    addr = LWSS_CELLS[{index[3:0], 3'b000} +: 8];
                    last = (index == 6'(LWSS_LEN - 1));
                end
            end
            PAT_PULSAR: begin
                addr = pulsar_addr(index);
                last = (index >= 6'(PULSAR_LEN - 1));
            end
            default: begin
                addr = '0;
                last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/life_ctrl.sv
// ---------------------------------------------------------------------------
// life_ctrl
// Sequencer and single write-port arbiter for the 16x16 Life map. Latches
// one-deep requests (generation, cell toggle, pattern load, random fill),
// grants them by fixed priority and drives exactly one map command per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : life_ctrl_if slave (requests in, commands/status out)
// All outputs are registered from the next-state values, so a command is
// visible in the same cycle the state register holds its state.
// ---------------------------------------------------------------------------
module life_ctrl
    import life_pkg::*;
#(
    parameter int          N_CELLS     = 256,
    parameter int          RAND_THRESH = 410,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    life_ctrl_if.slave    bus
);

    localparam logic [7:0]  FILL_LAST = 8'(N_CELLS - 1);
    localparam logic [10:0] THRESH    = 11'(RAND_THRESH);

    state_e      state_reg, state_next;
    logic        gen_p_reg, gen_p_next;
    logic        edit_p_reg, edit_p_next;
    logic        pat_p_reg, pat_p_next;
    logic        rand_p_reg, rand_p_next;
    logic [7:0]  edit_addr_reg, edit_addr_next;
    pat_e        pat_sel_reg, pat_sel_next;   // captured with the request
    pat_e        pat_act_reg, pat_act_next;   // pattern being loaded
    logic [5:0]  idx_reg, idx_next;
    logic        last_reg;
    logic [7:0]  fill_addr_reg, fill_addr_next;
    logic [15:0] lfsr_reg, lfsr_next;
    logic [15:0] gen_count_reg, gen_count_next;

    logic        gen_en_reg, gen_en_next;
    logic        map_clr_reg, map_clr_next;
    logic        wr_en_reg, wr_en_next;
    logic        wr_op_reg, wr_op_next;
    logic [7:0]  wr_addr_reg, wr_addr_next;
    logic        wr_data_reg, wr_data_next;
    logic        busy_reg, busy_next;
    logic        overrun_reg, overrun_next;

    logic        gen_req;
    logic [7:0]  rom_addr;
    logic        rom_last;

    // The ROM is addressed with the upcoming index so its cell lands in the
    // output register together with the LOAD state. Its last flag is kept
    // alongside so LOAD knows when the cell on the port is the final one.
    life_pattern_rom u_rom (
        .pat_sel (pat_act_next),
        .index   (idx_next),
        .addr    (rom_addr),
        .last    (rom_last)
    );

    assign gen_req   = bus.run ? bus.tick : bus.step_req;
    assign lfsr_next = {lfsr_reg[14:0],
                        lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    // Next state, grants and request latching
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        fill_addr_next = fill_addr_reg;
        pat_act_next   = pat_act_reg;
        gen_p_next     = gen_p_reg;
        edit_p_next    = edit_p_reg;
        pat_p_next     = pat_p_reg;
        rand_p_next    = rand_p_reg;
        edit_addr_next = edit_addr_reg;
        pat_sel_next   = pat_sel_reg;
        overrun_next   = bus.run & bus.tick & gen_p_reg;

        case (state_reg)
            ST_IDLE: begin
                // Edit-mode requests are only eligible while stopped; a
                // rising run discards them in the same cycle.
                if (pat_p_reg && !bus.run) begin
                    state_next   = ST_CLR;
                    pat_p_next   = 1'b0;
                    pat_act_next = pat_sel_reg;
                end else if (rand_p_reg && !bus.run) begin
                    state_next     = ST_FILL;
                    rand_p_next    = 1'b0;
                    fill_addr_next = '0;
                end else if (edit_p_reg && !bus.run) begin
                    state_next  = ST_EDIT;
                    edit_p_next = 1'b0;
                end else if (gen_p_reg) begin
                    state_next = ST_GEN;
                    gen_p_next = 1'b0;
                end
            end
            ST_GEN, ST_EDIT: state_next = ST_IDLE;
            ST_CLR: begin
                if (pat_act_reg == PAT_CLEAR) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_LOAD;
                    idx_next   = '0;
                end
            end
            ST_LOAD: begin
                if (last_reg) state_next = ST_IDLE;
                else          idx_next   = idx_reg + 6'd1;
            end
            ST_FILL: begin
                if (fill_addr_reg == FILL_LAST) state_next = ST_IDLE;
                else fill_addr_next = fill_addr_reg + 8'd1;
            end
            default: state_next = ST_IDLE;
        endcase

        // A request whose flag is already set (even if granted this cycle)
        // is dropped; only a dropped tick is reported.
        if (gen_req && !gen_p_reg) gen_p_next = 1'b1;

        if (bus.run) begin
            edit_p_next = 1'b0;
            pat_p_next  = 1'b0;
            rand_p_next = 1'b0;
        end else begin
            if (bus.edit_req && !edit_p_reg) begin
                edit_p_next    = 1'b1;
                edit_addr_next = {bus.edit_y, bus.edit_x};
            end
            if (bus.pat_req && !pat_p_reg) begin
                pat_p_next   = 1'b1;
                pat_sel_next = pat_e'(bus.pat_sel);
            end
            if (bus.rand_req && !rand_p_reg) rand_p_next = 1'b1;
        end
    end

    // Outputs for the state about to be entered
    always_comb begin
        gen_en_next    = 1'b0;
        map_clr_next   = 1'b0;
        wr_en_next     = 1'b0;
        wr_op_next     = 1'b0;
        wr_addr_next   = '0;
        wr_data_next   = 1'b0;
        gen_count_next = gen_count_reg;
        busy_next      = (state_next != ST_IDLE);

        case (state_next)
            ST_GEN: begin
                gen_en_next    = 1'b1;
                gen_count_next = gen_count_reg + 16'd1;
            end
            ST_EDIT: begin
                wr_en_next   = 1'b1;
                wr_op_next   = 1'b1;
                wr_addr_next = edit_addr_reg;
            end
            ST_CLR: begin
                map_clr_next   = 1'b1;
                gen_count_next = '0;
            end
            ST_LOAD: begin
                wr_en_next   = 1'b1;
                wr_data_next = 1'b1;
                wr_addr_next = rom_addr;
            end
            ST_FILL: begin
                wr_en_next   = 1'b1;
                wr_addr_next = fill_addr_next;
                wr_data_next = ({1'b0, lfsr_reg[9:0]} < THRESH);
                if (state_reg == ST_IDLE) gen_count_next = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            gen_p_reg     <= 1'b0;
            edit_p_reg    <= 1'b0;
            pat_p_reg     <= 1'b0;
            rand_p_reg    <= 1'b0;
            edit_addr_reg <= '0;
            pat_sel_reg   <= PAT_CLEAR;
            pat_act_reg   <= PAT_CLEAR;
            idx_reg       <= '0;
            last_reg      <= 1'b0;
            fill_addr_reg <= '0;
            lfsr_reg      <= LFSR_SEED;
            gen_count_reg <= '0;
            gen_en_reg    <= 1'b0;
            map_clr_reg   <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_op_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            gen_p_reg     <= gen_p_next;
            edit_p_reg    <= edit_p_next;
            pat_p_reg     <= pat_p_next;
            rand_p_reg    <= rand_p_next;
            edit_addr_reg <= edit_addr_next;
            pat_sel_reg   <= pat_sel_next;
            pat_act_reg   <= pat_act_next;
            idx_reg       <= idx_next;
            last_reg      <= rom_last;
            fill_addr_reg <= fill_addr_next;
            lfsr_reg      <= lfsr_next;
            gen_count_reg <= gen_count_next;
            gen_en_reg    <= gen_en_next;
            map_clr_reg   <= map_clr_next;
            wr_en_reg     <= wr_en_next;
            wr_op_reg     <= wr_op_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            busy_reg      <= busy_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign bus.gen_en    = gen_en_reg;
    assign bus.map_clr   = map_clr_reg;
    assign bus.wr_en     = wr_en_reg;
    assign bus.wr_op     = wr_op_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.wr_data   = wr_data_reg;
    assign bus.busy      = busy_reg;
    assign bus.gen_count = gen_count_reg;
    assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_life_ctrl.sv
// ---------------------------------------------------------------------------
// tb_life_ctrl
// Scoreboard bench for life_ctrl. Stimulus pushes the expected command
// sequence into a queue; a monitor on the falling edge pops and compares
// every command the DUT issues. Pattern cell sets, fill addresses, the
// generation count and overrun count come from a behavioural model.
// ---------------------------------------------------------------------------
module tb_life_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    life_ctrl_if bus();

    life_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [4:0] M_TICK = 5'b00001;
    localparam logic [4:0] M_STEP = 5'b00010;
    localparam logic [4:0] M_EDIT = 5'b00100;
    localparam logic [4:0] M_PAT  = 5'b01000;
    localparam logic [4:0] M_RAND = 5'b10000;

    typedef enum int {K_GEN, K_CLR, K_EDIT, K_LOAD, K_FILL} kind_t;
    typedef struct {
        kind_t kind;
        int    addr;
        int    pat;
        int    cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   pulse_cyc = 0;
    int   ovr_seen = 0;
    int   ovr_exp = 0;
    int   live = 0;
    int   gc_model = 0;
    bit   pat_cells [4][256];
    int   pat_len [4];
    bit   seen [256];
    int   glider_list [5] = '{0, 17, 18, 32, 33};
    int   lwss_list [9]   = '{101, 104, 121, 133, 137, 150, 151, 152, 153};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                      name, act, act, req, req, cyc);
    endtask

    function automatic bit on_edge(input int v);
        return (v == 0) || (v == 5) || (v == 7) || (v == 12);
    endfunction

    function automatic bit on_span(input int v);
        return (v >= 2 && v <= 4) || (v >= 8 && v <= 10);
    endfunction

    task automatic build_model();
        for (int p = 0; p < 4; p++)
            for (int a = 0; a < 256; a++) pat_cells[p][a] = 1'b0;
        foreach (glider_list[i]) pat_cells[1][glider_list[i]] = 1'b1;
        foreach (lwss_list[i])   pat_cells[2][lwss_list[i]] = 1'b1;
        // 13x13 pulsar box placed at (1,1) on the 16x16 map
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                int dy = y - 1;
                int dx = x - 1;
                if ((on_edge(dy) && on_span(dx)) || (on_edge(dx) && on_span(dy)))
                    pat_cells[3][y*16 + x] = 1'b1;
            end
        for (int p = 0; p < 4; p++) begin
            pat_len[p] = 0;
            for (int a = 0; a < 256; a++) pat_len[p] += int'(pat_cells[p][a]);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t m_e;
    int   m_kind;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.overrun) ovr_seen++;
            if (bus.gen_en || bus.map_clr || bus.wr_en) begin
                chk("single_cmd", int'(bus.gen_en) + int'(bus.map_clr) + int'(bus.wr_en), 1);
                chk("cmd_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    m_e = q.pop_front();
                    if (bus.gen_en)       m_kind = K_GEN;
                    else if (bus.map_clr) m_kind = K_CLR;
                    else if (bus.wr_op)   m_kind = K_EDIT;
                    else                  m_kind = (m_e.kind == K_FILL) ? K_FILL : K_LOAD;
                    chk("cmd_kind", m_kind, int'(m_e.kind));
                    if (m_kind == int'(m_e.kind)) begin
                        case (m_e.kind)
                            K_GEN: if (m_e.cyc >= 0) chk("gen_latency", cyc, m_e.cyc);
                            K_CLR: for (int a = 0; a < 256; a++) seen[a] = 1'b0;
                            K_EDIT: chk("edit_addr", int'(bus.wr_addr), m_e.addr);
                            K_LOAD: begin
                                chk("load_data", int'(bus.wr_data), 1);
                                chk("load_cell_in_pattern",
                                    int'(pat_cells[m_e.pat][bus.wr_addr] && !seen[bus.wr_addr]), 1);
                                seen[bus.wr_addr] = 1'b1;
                            end
                            K_FILL: begin
                                chk("fill_addr", int'(bus.wr_addr), m_e.addr);
                                live += int'(bus.wr_data);
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fire(input logic [4:0] m);
        @(negedge clk);
        pulse_cyc    = cyc;
        bus.tick     = m[0];
        bus.step_req = m[1];
        bus.edit_req = m[2];
        bus.pat_req  = m[3];
        bus.rand_req = m[4];
    endtask

    task automatic release_req();
        @(negedge clk);
        bus.tick     = 1'b0;
        bus.step_req = 1'b0;
        bus.edit_req = 1'b0;
        bus.pat_req  = 1'b0;
        bus.rand_req = 1'b0;
    endtask

    task automatic push(input kind_t k, input int addr, input int pat, input int c);
        exp_t e;
        e.kind = k;
        e.addr = addr;
        e.pat  = pat;
        e.cyc  = c;
        q.push_back(e);
    endtask

    // Waits until busy has been seen and then stays low for 3 cycles.
    task automatic wait_idle(input int budget, output int busy_cnt);
        int low_run;
        bit seen_busy;
        bit timed_out;
        busy_cnt  = 0;
        low_run   = 0;
        seen_busy = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.busy) begin
                busy_cnt++;
                seen_busy = 1'b1;
                low_run   = 0;
            end else begin
                low_run++;
                if (seen_busy && low_run >= 3) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        chk("idle_timeout", int'(timed_out), 0);
    endtask

    task automatic do_edit(input int x, input int y);
        int b;
        bus.edit_x = 4'(x);
        bus.edit_y = 4'(y);
        fire(M_EDIT);
        push(K_EDIT, y*16 + x, 0, -1);
        release_req();
        wait_idle(50, b);
        chk("edit_busy_cycles", b, 1);
        $display("edit x=%0d y=%0d busy=%0d", x, y, b);
    endtask

    task automatic do_step();
        int b;
        fire(M_STEP);
        push(K_GEN, 0, 0, pulse_cyc + 2);
        release_req();
        wait_idle(50, b);
        gc_model = (gc_model + 1) % 65536;
        chk("step_gen_count", int'(bus.gen_count), gc_model);
        $display("step gen_count=%0d", bus.gen_count);
    endtask

    task automatic do_pattern(input int p);
        int b;
        bus.pat_sel = 2'(p);
        fire(M_PAT);
        push(K_CLR, 0, p, -1);
        for (int i = 0; i < pat_len[p]; i++) push(K_LOAD, 0, p, -1);
        release_req();
        wait_idle(200, b);
        gc_model = 0;
        chk("pattern_busy_cycles", b, 1 + pat_len[p]);
        chk("pattern_gen_count", int'(bus.gen_count), gc_model);
        $display("pattern sel=%0d busy=%0d cells=%0d", p, b, pat_len[p]);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_gen_en"},    int'(bus.gen_en), 0);
        chk({tag, "_map_clr"},   int'(bus.map_clr), 0);
        chk({tag, "_wr_en"},     int'(bus.wr_en), 0);
        chk({tag, "_wr_op"},     int'(bus.wr_op), 0);
        chk({tag, "_wr_addr"},   int'(bus.wr_addr), 0);
        chk({tag, "_wr_data"},   int'(bus.wr_data), 0);
        chk({tag, "_overrun"},   int'(bus.overrun), 0);
        chk({tag, "_busy"},      int'(bus.busy), 0);
        chk({tag, "_gen_count"}, int'(bus.gen_count), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int b;
        bit found;
        bus.run = 1'b0;
        bus.edit_x = '0;
        bus.edit_y = '0;
        bus.pat_sel = '0;
        bus.tick = 1'b0;
        bus.step_req = 1'b0;
        bus.edit_req = 1'b0;
        bus.pat_req = 1'b0;
        bus.rand_req = 1'b0;
        build_model();

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
        $display("reset released, outputs checked");

        // Run mode: three ticks, each GEN two cycles later
        bus.run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fire(M_TICK);
            push(K_GEN, 0, 0, pulse_cyc + 2);
            release_req();
            repeat ($urandom_range(8, 12)) @(negedge clk);
            gc_model++;
            $display("tick %0d gen_count=%0d", i, bus.gen_count);
        end
        chk("run_gen_count", int'(bus.gen_count), gc_model);

        // Stop-mode requests are ignored while running
        fire(M_STEP | M_EDIT | M_PAT | M_RAND);
        release_req();
        repeat (8) @(negedge clk);
        chk("ignored_busy", int'(bus.busy), 0);
        chk("ignored_gen_count", int'(bus.gen_count), gc_model);
        $display("stop-mode requests while running: busy=%0d", bus.busy);

        bus.run = 1'b0;
        repeat (2) @(negedge clk);
        do_edit(5, 3);
        for (int i = 0; i < 3; i++) do_edit($urandom_range(0, 15), $urandom_range(0, 15));
        do_step();

        do_pattern(1);
        do_step();
        do_pattern(2);
        do_pattern(3);
        do_pattern(0);
        do_pattern($urandom_range(1, 3));

        // Ticks during a long fill: one is kept, the next one overruns
        live = 0;
        fire(M_RAND);
        for (int a = 0; a < 256; a++) push(K_FILL, a, 0, -1);
        release_req();
        repeat (20) @(negedge clk);
        bus.run = 1'b1;
        repeat (10) @(negedge clk);
        fire(M_TICK);
        push(K_GEN, 0, 0, -1);
        release_req();
        repeat (30) @(negedge clk);
        fire(M_TICK);
        ovr_exp++;
        release_req();
        wait_idle(400, b);
        bus.run = 1'b0;
        gc_model = 1;
        chk("fill1_live_range", int'(live >= 72 && live <= 132), 1);
        chk("fill1_gen_count", int'(bus.gen_count), gc_model);
        chk("fill1_overrun", ovr_seen, ovr_exp);
        $display("fill+overrun live=%0d busy=%0d overruns=%0d", live, b, ovr_seen);

        // Simultaneous fill, edit, step: served by priority
        live = 0;
        bus.edit_x = 4'($urandom_range(0, 15));
        bus.edit_y = 4'($urandom_range(0, 15));
        fire(M_RAND | M_EDIT | M_STEP);
        for (int a = 0; a < 256; a++) push(K_FILL, a, 0, -1);
        push(K_EDIT, int'(bus.edit_y) * 16 + int'(bus.edit_x), 0, -1);
        push(K_GEN, 0, 0, -1);
        release_req();
        wait_idle(400, b);
        gc_model = 1;
        chk("fill2_live_range", int'(live >= 72 && live <= 132), 1);
        chk("fill2_gen_count", int'(bus.gen_count), gc_model);
        chk("fill2_busy_cycles", b, 258);
        $display("fill+edit+step live=%0d busy=%0d", live, b);

        // Reset in the middle of a glider load
        bus.pat_sel = 2'd1;
        fire(M_PAT);
        push(K_CLR, 0, 1, -1);
        for (int i = 0; i < pat_len[1]; i++) push(K_LOAD, 0, 1, -1);
        release_req();
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wr_en && bus.wr_addr == 8'd18) begin
                found = 1'b1;
                break;
            end
        end
        chk("load_index2_reached", int'(found), 1);
        #1 rst = 1'b1;
        #1;
        check_outputs_zero("midload_reset");
        q.delete();
        gc_model = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset during load, outputs checked");
        do_pattern($urandom_range(1, 3));

        // Random stop-mode traffic
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0: do_edit($urandom_range(0, 15), $urandom_range(0, 15));
                1: do_step();
                default: do_pattern($urandom_range(0, 3));
            endcase
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("overrun_total", ovr_seen, ovr_exp);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
